// File: rtl/div_seq.sv
// div_seq: sequential unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk         - rising-edge clock
//   reset_n     - asynchronous active-low reset
//   op_start    - launch request, only honoured in IDLE
//   op_clear    - synchronous clear / acknowledge, wins over everything
//   dividend    - unsigned dividend, captured on the accepted start edge
//   divisor     - unsigned divisor, captured on the same edge
//   quotient    - registered quotient, valid while op_done = 1
//   remainder   - registered remainder, valid while op_done = 1
//   busy        - high while iterating
//   op_done     - high while results are presented
//   div_by_zero - high in DONE when the captured divisor was zero
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             op_done,
    output logic             div_by_zero
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StDone = 2'b01,
        StExec = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  wquot_q, wquot_d;    // working quotient, seeded with the dividend
    logic [WIDTH-1:0]  prem_q, prem_d;      // partial remainder
    logic [WIDTH-1:0]  divisor_q, divisor_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  quot_out_q, quot_out_d;
    logic [WIDTH-1:0]  rem_out_q, rem_out_d;
    logic              dbz_q, dbz_d;

    // One restoring iteration.
    logic [WIDTH:0]    trial;
    logic              trial_ge;
    logic [WIDTH-1:0]  trial_diff;
    logic [WIDTH-1:0]  prem_step;
    logic [WIDTH-1:0]  wquot_step;
    logic              cnt_last;

    always_comb begin
        trial      = {prem_q, wquot_q[WIDTH-1]};
        trial_ge   = trial >= {1'b0, divisor_q};
        // The true difference is below the divisor, so the low WIDTH bits are exact.
        trial_diff = trial[WIDTH-1:0] - divisor_q;
        prem_step  = trial_ge ? trial_diff : trial[WIDTH-1:0];
        wquot_step = {wquot_q[WIDTH-2:0], trial_ge};
        cnt_last   = (cnt_q == CntW'(WIDTH - 1));
    end

    always_comb begin
        state_d    = state_q;
        wquot_d    = wquot_q;
        prem_d     = prem_q;
        divisor_d  = divisor_q;
        cnt_d      = cnt_q;
        quot_out_d = quot_out_q;
        rem_out_d  = rem_out_q;
        dbz_d      = dbz_q;

        if (op_clear) begin
            state_d    = StIdle;
            wquot_d    = '0;
            prem_d     = '0;
            divisor_d  = '0;
            cnt_d      = '0;
            quot_out_d = '0;
            rem_out_d  = '0;
            dbz_d      = 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (op_start) begin
                        divisor_d = divisor;
                        if (divisor != '0) begin
                            state_d = StExec;
                            wquot_d = dividend;
                            prem_d  = '0;
                            cnt_d   = '0;
                        end else begin
                            state_d    = StDone;
                            quot_out_d = '1;
                            rem_out_d  = dividend;
                            dbz_d      = 1'b1;
                        end
                    end
                end
                StExec: begin
                    wquot_d = wquot_step;
                    prem_d  = prem_step;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_last) begin
                        state_d    = StDone;
                        quot_out_d = wquot_step;
                        rem_out_d  = prem_step;
                    end
                end
                StDone: begin
                    // Hold results until acknowledged by op_clear.
                end
                default: begin
                    // Unused code 11: recover to a clean IDLE.
                    state_d    = StIdle;
                    wquot_d    = '0;
                    prem_d     = '0;
                    divisor_d  = '0;
                    cnt_d      = '0;
                    quot_out_d = '0;
                    rem_out_d  = '0;
                    dbz_d      = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StIdle;
            wquot_q    <= '0;
            prem_q     <= '0;
            divisor_q  <= '0;
            cnt_q      <= '0;
            quot_out_q <= '0;
            rem_out_q  <= '0;
            dbz_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wquot_q    <= wquot_d;
            prem_q     <= prem_d;
            divisor_q  <= divisor_d;
            cnt_q      <= cnt_d;
            quot_out_q <= quot_out_d;
            rem_out_q  <= rem_out_d;
            dbz_q      <= dbz_d;
        end
    end

    assign quotient    = quot_out_q;
    assign remainder   = rem_out_q;
    assign busy        = (state_q == StExec);
    assign op_done     = (state_q == StDone);
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: scoreboard bench for div_seq (WIDTH = 32). The driver pushes the
// expected result of every launched division; a monitor pops and compares on
// each rising edge of op_done.
module tb_div_seq;

    localparam int unsigned W = 32;

    logic         clk;
    logic         reset_n;
    logic         op_start;
    logic         op_clear;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         op_done;
    logic         div_by_zero;

    div_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .op_start    (op_start),
        .op_clear    (op_clear),
        .dividend    (dividend),
        .divisor     (divisor),
        .quotient    (quotient),
        .remainder   (remainder),
        .busy        (busy),
        .op_done     (op_done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   done_rises = 0;
    logic done_prev = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: compare on every rising edge of op_done.
    always @(negedge clk) begin
        if (op_done && !done_prev) begin
            done_rises <= done_rises + 1;
            if (sb.size() == 0) begin
                check("unexpected_done", {31'd0, op_done}, '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("quotient", quotient, e.q);
                check("remainder", remainder, e.r);
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
            end
        end
        done_prev <= op_done;
    end

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, {31'd0, busy}, '0);
        check({tag, "_op_done"}, {31'd0, op_done}, '0);
        check({tag, "_dbz"}, {31'd0, div_by_zero}, '0);
        check({tag, "_quotient"}, quotient, '0);
        check({tag, "_remainder"}, remainder, '0);
    endtask

    // Launch one division, wait for DONE, check latency/busy width, optionally clear.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er,
                         input logic edbz, input bit clear_after, input bit timing_chk);
        exp_t e;
        int   busy_cnt;
        int   cyc;
        e.q = eq;
        e.r = er;
        e.dbz = edbz;
        sb.push_back(e);
        @(negedge clk);
        op_start = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        op_start = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        busy_cnt = 0;
        cyc      = 0;
        while (!op_done && cyc < int'(W) + 4) begin
            if (busy) busy_cnt++;
            cyc++;
            @(negedge clk);
        end
        if (!op_done) begin
            check("done_timeout", {31'd0, op_done}, 32'd1);
        end else if (timing_chk) begin
            check("latency", cyc, edbz ? 32'd0 : W);
            check("busy_cycles", busy_cnt, edbz ? 32'd0 : W);
        end
        if (clear_after) begin
            // Result holds in DONE even if op_start is pulsed.
            op_start = 1'b1;
            @(negedge clk);
            op_start = 1'b0;
            if (timing_chk) begin
                check("done_hold", {31'd0, op_done}, 32'd1);
                check("q_hold", quotient, eq);
            end
            op_clear = 1'b1;
            @(negedge clk);
            op_clear = 1'b0;
            if (timing_chk) check_idle_outputs("after_clear");
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rises_before;
        int busy_seen;
        op_start = 1'b0;
        op_clear = 1'b0;
        dividend = '0;
        divisor  = '0;
        reset_n  = 1'b1;
        #1 reset_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Directed vectors.
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1, 1'b1);
        do_op(32'd5, 32'd9, 32'd0, 32'd5, 1'b0, 1'b1, 1'b1);
        do_op(32'd0, 32'd3, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
        do_op(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b1);
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b1, 1'b1);
        do_op(32'd1234, 32'd0, 32'hFFFF_FFFF, 32'd1234, 1'b1, 1'b1, 1'b1);

        // Abort: ignored op_start at cycle 10, op_clear at cycle 20.
        rises_before = done_rises;
        busy_seen = 0;
        @(negedge clk);
        op_start = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        @(negedge clk);
        op_start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            if (busy) busy_seen++;
            if (c == 10) begin
                op_start = 1'b1;
                dividend = 32'd555;
                divisor  = 32'd5;
            end else begin
                op_start = 1'b0;
            end
            @(negedge clk);
        end
        check("abort_busy_before", busy_seen, 32'd19);
        op_clear = 1'b1;
        @(negedge clk);
        op_clear = 1'b0;
        check_idle_outputs("abort");
        repeat (W + 4) @(negedge clk);
        check("abort_no_done", done_rises - rises_before, 32'd0);
        do_op(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 1'b1, 1'b1);

        // Clear and start together in IDLE: clear wins.
        @(negedge clk);
        op_start = 1'b1;
        op_clear = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd0;
        @(negedge clk);
        op_start = 1'b0;
        op_clear = 1'b0;
        check_idle_outputs("clear_vs_start");

        // Asynchronous reset between edges while in DONE.
        do_op(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("async_rst_done");
        @(negedge clk);
        reset_n = 1'b1;

        // Asynchronous reset mid-EXEC.
        @(negedge clk);
        op_start = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd5;
        @(negedge clk);
        op_start = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_before_rst", {31'd0, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_idle_outputs("async_rst_exec");
        @(negedge clk);
        reset_n = 1'b1;
        rises_before = done_rises;
        repeat (W + 4) @(negedge clk);
        check("rst_no_done", done_rises - rises_before, 32'd0);

        // Bulk vectors against the integer reference.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = $urandom;
            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            do_op(a, b, a / b, a % b, 1'b0, 1'b1, 1'b0);
        end

        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
